// File: rtl/rv32i_types.sv
// Shared RV32I decode types: fetch/dispatch stage records, ALU enums, decode-queue defaults.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package rv32i_types;

    localparam int DECODE_WIDTH = 2;
    localparam int DECODE_DEPTH = 8;

    localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;
    localparam logic [6:0] FUNCT7_VARIANT = 7'b0100000;

    typedef enum logic [6:0] {
        op_b_lui   = 7'b0110111,
        op_b_auipc = 7'b0010111,
        op_b_jal   = 7'b1101111,
        op_b_jalr  = 7'b1100111,
        op_b_br    = 7'b1100011,
        op_b_load  = 7'b0000011,
        op_b_store = 7'b0100011,
        op_b_imm   = 7'b0010011,
        op_b_reg   = 7'b0110011
    } rv32i_opcode_t;

    // Encodings 0..7 line up with funct3 so ALU-class ops map directly.
    typedef enum logic [3:0] {
        alu_add  = 4'd0,
        alu_sll  = 4'd1,
        alu_slt  = 4'd2,
        alu_sltu = 4'd3,
        alu_xor  = 4'd4,
        alu_srl  = 4'd5,
        alu_or   = 4'd6,
        alu_and  = 4'd7,
        alu_sub  = 4'd8,
        alu_sra  = 4'd9
    } alu_ops;

    typedef enum logic [1:0] {
        rs1_out = 2'd0,
        pc_out  = 2'd1,
        no_out  = 2'd2
    } alu_m1_sel_t;

    typedef enum logic {
        rs2_out = 1'b0,
        imm_out = 1'b1
    } alu_m2_sel_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] order;
        logic        valid;
    } if_id_stage_reg_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] order;
        logic        valid;
        logic        illegal;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        regf_we;
        alu_m1_sel_t alu_m1_sel;
        alu_m2_sel_t alu_m2_sel;
        alu_ops      aluop;
    } id_dis_stage_reg_t;

endpackage

// File: rtl/rv32i_decoder.sv
// Full RV32I decode of one fetched instruction into a dispatch record.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is stored.
module rv32i_decoder
    import rv32i_types::*;
(
    input  if_id_stage_reg_t  fetch,
    output id_dis_stage_reg_t dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = fetch.inst[6:0];
    assign rd_f   = fetch.inst[11:7];
    assign funct3 = fetch.inst[14:12];
    assign rs1_f  = fetch.inst[19:15];
    assign rs2_f  = fetch.inst[24:20];
    assign funct7 = fetch.inst[31:25];

    assign imm_i = {{21{fetch.inst[31]}}, fetch.inst[30:20]};
    assign imm_s = {{21{fetch.inst[31]}}, fetch.inst[30:25], fetch.inst[11:7]};
    assign imm_b = {{20{fetch.inst[31]}}, fetch.inst[7], fetch.inst[30:25], fetch.inst[11:8], 1'b0};
    assign imm_u = {fetch.inst[31:12], 12'h000};
    assign imm_j = {{12{fetch.inst[31]}}, fetch.inst[19:12], fetch.inst[20], fetch.inst[30:21], 1'b0};

    // Opcode-driven field selection; everything not set by an opcode stays zero.
    always_comb begin
        dec       = '0;
        dec.inst  = fetch.inst;
        dec.pc    = fetch.pc;
        dec.order = fetch.order;
        dec.valid = fetch.valid;
        case (opcode)
            op_b_lui: begin
                dec.imm        = imm_u;
                dec.alu_m1_sel = no_out;
                dec.alu_m2_sel = imm_out;
                dec.aluop      = alu_add;
                dec.regf_we    = 1'b1;
                dec.rd_addr    = rd_f;
            end
            op_b_auipc: begin
                dec.imm        = imm_u;
                dec.alu_m1_sel = pc_out;
                dec.alu_m2_sel = imm_out;
                dec.aluop      = alu_add;
                dec.regf_we    = 1'b1;
                dec.rd_addr    = rd_f;
            end
            op_b_imm: begin
                dec.imm        = imm_i;
                dec.alu_m1_sel = rs1_out;
                dec.alu_m2_sel = imm_out;
                dec.aluop      = alu_ops'({1'b0, funct3});
                if (funct3 == 3'b101 && funct7 == FUNCT7_VARIANT) begin
                    dec.aluop = alu_sra;
                end
                dec.regf_we    = 1'b1;
                dec.rd_addr    = rd_f;
                dec.rs1_addr   = rs1_f;
            end
            op_b_reg: begin
                if (funct7 != FUNCT7_BASE && funct7 != FUNCT7_VARIANT) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.alu_m1_sel = rs1_out;
                    dec.alu_m2_sel = rs2_out;
                    dec.aluop      = alu_ops'({1'b0, funct3});
                    if (funct7 == FUNCT7_VARIANT && funct3 == 3'b000) begin
                        dec.aluop = alu_sub;
                    end
                    if (funct7 == FUNCT7_VARIANT && funct3 == 3'b101) begin
                        dec.aluop = alu_sra;
                    end
                    dec.regf_we  = 1'b1;
                    dec.rd_addr  = rd_f;
                    dec.rs1_addr = rs1_f;
                    dec.rs2_addr = rs2_f;
                end
            end
            op_b_jal: begin
                dec.imm     = imm_j;
                dec.regf_we = 1'b1;
                dec.rd_addr = rd_f;
            end
            op_b_jalr: begin
                dec.imm      = imm_i;
                dec.regf_we  = 1'b1;
                dec.rd_addr  = rd_f;
                dec.rs1_addr = rs1_f;
            end
            op_b_br: begin
                dec.imm      = imm_b;
                dec.rs1_addr = rs1_f;
                dec.rs2_addr = rs2_f;
            end
            op_b_load: begin
                dec.imm      = imm_i;
                dec.regf_we  = 1'b1;
                dec.rd_addr  = rd_f;
                dec.rs1_addr = rs1_f;
            end
            op_b_store: begin
                dec.imm      = imm_s;
                dec.rs1_addr = rs1_f;
                dec.rs2_addr = rs2_f;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        // x0 is never written, whatever the opcode claimed.
        if (dec.rd_addr == 5'd0) begin
            dec.regf_we = 1'b0;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Decodes up to WIDTH fetched lanes per cycle into an in-order circular queue; dispatch drains up to WIDTH.
// Latency: one cycle from enqueue edge to out_bundle/out_valid.
// Backpressure: in_ready low unless a full WIDTH-lane group fits in registered free space; input then ignored.
module decode_queue
    import rv32i_types::*;
#(
    parameter int WIDTH = DECODE_WIDTH,
    parameter int DEPTH = DECODE_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [WIDTH-1:0]                    in_valid,
    input  if_id_stage_reg_t [WIDTH-1:0]        in_bundle,
    output logic                                in_ready,
    output id_dis_stage_reg_t [WIDTH-1:0]       out_bundle,
    output logic [WIDTH-1:0]                    out_valid,
    input  logic [$clog2(WIDTH+1)-1:0]          deq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    id_dis_stage_reg_t [WIDTH-1:0] dec;
    id_dis_stage_reg_t             mem_q [DEPTH];
    id_dis_stage_reg_t             mem_d [DEPTH];
    logic [PTR_W-1:0]              head_q, head_d;
    logic [PTR_W-1:0]              tail_q, tail_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [CNT_W-1:0]              enq_n;
    logic [CNT_W-1:0]              deq_n;
    logic [CNT_W-1:0]              deq_req;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        rv32i_decoder u_dec (
            .fetch (in_bundle[g]),
            .dec   (dec[g])
        );
        assign out_bundle[g] = mem_q[head_q + PTR_W'(g)];
        assign out_valid[g]  = count_q > CNT_W'(g);
    end

    // Registered count only, so a same-cycle dequeue never reaches in_ready.
    assign in_ready = count_q <= READY_MAX;
    assign deq_req  = CNT_W'(deq_count);

    // Compact valid lanes into tail onward, clamp dequeue to occupancy, flush wins.
    always_comb begin
        mem_d = mem_q;
        enq_n = '0;
        deq_n = (deq_req > count_q) ? count_q : deq_req;
        if (in_ready) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_valid[i]) begin
                    mem_d[tail_q + enq_n[PTR_W-1:0]] = dec[i];
                    enq_n = enq_n + CNT_ONE;
                end
            end
        end
        head_d  = head_q + deq_n[PTR_W-1:0];
        tail_d  = tail_q + enq_n[PTR_W-1:0];
        count_d = count_q + enq_n - deq_n;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Queue state; storage is cleared on reset so unread slots never show X.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule
